// File: rtl/rdma_tx_scheduler.sv
// rdma_tx_scheduler: round-robin arbiter that feeds RDMA work requests, one at a
// time, into the single tx header inserter. It assigns a per-requester 24-bit PSN,
// drives the inserter's start pulse and header fields, and waits for completion
// under a watchdog.
module rdma_tx_scheduler #(
  parameter int                  N_REQ       = 4,
  parameter int                  MAX_LEN     = 4096,
  parameter int                  WDOG_CYCLES = 65535,
  // Reset value of each requester's PSN counter (requester i in bits [24i+23:24i]).
  // Zero gives the normal power-up sequence; other values serve as a preload.
  parameter logic [N_REQ*24-1:0] PSN_INIT    = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*8-1:0]    req_opcode,
  input  logic [N_REQ*24-1:0]   req_dest_qp,
  input  logic [N_REQ*64-1:0]   req_remote_addr,
  input  logic [N_REQ*32-1:0]   req_length,
  output logic                  hi_start_tx,
  output logic [7:0]            hi_opcode,
  output logic [23:0]           hi_psn,
  output logic [23:0]           hi_dest_qp,
  output logic [63:0]           hi_remote_addr,
  output logic [31:0]           hi_length,
  input  logic                  hi_tx_busy,
  input  logic                  hi_tx_done,
  output logic                  grant_valid,
  output logic [2:0]            grant_id,
  output logic                  err_len,
  output logic                  err_timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t r_state, w_state_next;

  // Arbitration and grant bookkeeping
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_gid;
  logic [PTR_W-1:0] w_pick;
  logic             w_found;

  // Descriptor holding registers, loaded at the handshake
  logic [7:0]  r_op;
  logic [23:0] r_qp;
  logic [63:0] r_addr;
  logic [31:0] r_len;

  // Per-requester PSN counters
  logic [23:0] r_psn [N_REQ];

  // Registered outputs
  logic        r_start;
  logic        r_grant_valid;
  logic [2:0]  r_grant_id;
  logic        r_err_len;
  logic        r_err_to;
  logic [7:0]  r_hi_op;
  logic [23:0] r_hi_psn;
  logic [23:0] r_hi_qp;
  logic [63:0] r_hi_addr;
  logic [31:0] r_hi_len;

  logic [WD_W-1:0] r_wdog;

  logic w_in_wait;
  logic w_len_ok;
  logic w_wdog_exp;
  logic w_done;
  logic w_timeout;

  // Per-requester views of the packed descriptor buses
  logic [7:0]  w_op   [N_REQ];
  logic [23:0] w_qp   [N_REQ];
  logic [63:0] w_addr [N_REQ];
  logic [31:0] w_len  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_op[gi]   = req_opcode[gi*8 +: 8];
      assign w_qp[gi]   = req_dest_qp[gi*24 +: 24];
      assign w_addr[gi] = req_remote_addr[gi*64 +: 64];
      assign w_len[gi]  = req_length[gi*32 +: 32];
    end
  endgenerate

  // (p + k) mod N_REQ for 0 <= k <= N_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[wrap_add(r_rr_ptr, i)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_rr_ptr, i);
      end
    end
  end

  assign w_in_wait  = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_len_ok   = (r_len != '0) && (r_len <= 32'(MAX_LEN));
  assign w_wdog_exp = (r_wdog == WD_W'(WDOG_CYCLES - 1));
  // Completion is honoured in WAIT_BUSY too, in case busy was too short to see
  assign w_done     = w_in_wait && hi_tx_done;
  assign w_timeout  = w_in_wait && !hi_tx_done && w_wdog_exp;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and the combinational handshake
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_pick] = 1'b1;
          w_state_next      = S_CHECK;
        end
      end
      S_CHECK:     w_state_next = w_len_ok ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_done || w_timeout) w_state_next = S_IDLE;
        else if (hi_tx_busy)     w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_done || w_timeout) w_state_next = S_IDLE;
      end
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Datapath: descriptor latch, header launch, PSN/rr update, watchdog, error pulses
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rr_ptr      <= '0;
      r_gid         <= '0;
      r_op          <= '0;
      r_qp          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_start       <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_err_len     <= 1'b0;
      r_err_to      <= 1'b0;
      r_hi_op       <= '0;
      r_hi_psn      <= '0;
      r_hi_qp       <= '0;
      r_hi_addr     <= '0;
      r_hi_len      <= '0;
      r_wdog        <= '0;
      for (int i = 0; i < N_REQ; i++) r_psn[i] <= PSN_INIT[i*24 +: 24];
    end else begin
      r_start   <= 1'b0;
      r_err_len <= 1'b0;
      r_err_to  <= 1'b0;

      if (r_state == S_IDLE && w_found) begin
        r_gid  <= w_pick;
        r_op   <= w_op[w_pick];
        r_qp   <= w_qp[w_pick];
        r_addr <= w_addr[w_pick];
        r_len  <= w_len[w_pick];
      end

      if (r_state == S_CHECK) begin
        if (w_len_ok) begin
          r_start       <= 1'b1;
          r_grant_valid <= 1'b1;
          r_grant_id    <= 3'(r_gid);
          r_hi_op       <= r_op;
          r_hi_psn      <= r_psn[r_gid];
          r_hi_qp       <= r_qp;
          r_hi_addr     <= r_addr;
          r_hi_len      <= r_len;
          r_wdog        <= '0;
        end else begin
          r_err_len <= 1'b1;
          r_rr_ptr  <= wrap_add(r_gid, 1);
        end
      end

      // Watchdog runs from the LAUNCH cycle onward
      if (r_state == S_LAUNCH || w_in_wait) r_wdog <= r_wdog + WD_W'(1);

      if (w_done) begin
        r_psn[r_gid]  <= r_psn[r_gid] + 24'd1;
        r_rr_ptr      <= wrap_add(r_gid, 1);
        r_grant_valid <= 1'b0;
      end

      if (w_timeout) begin
        r_err_to      <= 1'b1;
        r_rr_ptr      <= wrap_add(r_gid, 1);
        r_grant_valid <= 1'b0;
      end
    end
  end

  assign hi_start_tx    = r_start;
  assign hi_opcode      = r_hi_op;
  assign hi_psn         = r_hi_psn;
  assign hi_dest_qp     = r_hi_qp;
  assign hi_remote_addr = r_hi_addr;
  assign hi_length      = r_hi_len;
  assign grant_valid    = r_grant_valid;
  assign grant_id       = r_grant_id;
  assign err_len        = r_err_len;
  assign err_timeout    = r_err_to;

endmodule
